sayeh_bus_unit: RTL
===================

// Module: sayeh_bus_unit
// PURPOSE
//  Parametrised bus interface unit for the next-generation SAYEH core. Arbitrates between
//  two internal request channels: instruction fetch (F) and data load/store/IO (D).
//  Drives the external ReadMem/WriteMem/ReadIO/WriteIO strobes, Addressbus and the
//  tristate Databus. Sequences the MemDataready wait handshake so the controller never
//  sees the bus protocol.
// PARAMETERS
//  DW       16   data bus width, bits
//  AW       16   address bus width, bits
//  IO_WAIT  1    IO strobe length in cycles (>=1); MemDataready ignored for IO
//  TIMEOUT  255  memory wait limit in cycles (used only with SAYEH_BUS_TIMEOUT_EN)
// PORTS
//  clk            in    1   single clock, all state on rising edge
//  ExternalReset  in    1   synchronous, active-high reset
//  f_req          in    1   fetch request, level, held until f_ack
//  f_addr         in    AW  fetch address, stable while f_req
//  f_ack          out   1   one-cycle fetch completion pulse
//  f_rdata        out   DW  fetch data; valid in f_ack cycle, held until next f_ack
//  d_req          in    1   data request, level, held until d_ack
//  d_we           in    1   1=write, 0=read
//  d_io           in    1   1=IO space, 0=memory space
//  d_addr         in    AW  data address
//  d_wdata        in    DW  write data
//  d_ack          out   1   one-cycle data completion pulse
//  d_rdata        out   DW  read data; valid in d_ack cycle, held until next d_ack
//  ReadMem/WriteMem/ReadIO/WriteIO  out 1 each  registered bus strobes, at most one high
//  Addressbus     out   AW  registered address, holds last value between accesses
//  Databus        inout DW  driven with latched wdata only while WriteMem|WriteIO, else Z
//  MemDataready   in    1   memory ready, sampled on rising edge during a memory strobe
//  bus_err        out   1   one-cycle pulse with ack on a timed-out access
// BEHAVIOUR
//  Reset: all strobes 0, Addressbus 0, f_ack=d_ack=0, f_rdata=d_rdata=0, bus_err=0.
//  Reset state: IDLE. Databus is Z.
//  FSM states: IDLE -> MEM | IO -> ACK -> IDLE.
//  IDLE:
//   - Sample f_req and d_req.
//   - Grant goes to D if only D requests, and to F if only F requests.
//   - If both request: D wins unless the last grant was D, in which case F wins
//     (alternation, no starvation).
//   - Latch the granted channel's addr, we, io and wdata. Go to MEM (d_io=0 or F) or IO.
//  MEM:
//   - Addressbus and ReadMem or WriteMem are high from the first MEM cycle.
//   - Stay in MEM while MemDataready=0.
//   - When MemDataready=1 is sampled: on a read, capture Databus into the channel rdata.
//     Go to ACK.
//  IO:
//   - ReadIO or WriteIO is high for exactly IO_WAIT cycles.
//   - On a read, Databus is captured at the edge ending the last cycle. Go to ACK.
//  ACK:
//   - Strobes are 0 and the granted channel's ack is 1 for exactly one cycle.
//   - req inputs are ignored in this cycle; the requester drops or renews req the next cycle.
//  Latency: req high in IDLE (cycle 0); strobe in cycle 1; ack in cycle 2 at the earliest.
//   A zero-wait memory access takes 3 cycles, req to next IDLE.
//  Writes: Databus is driven for the whole strobe. Ack does not return data; rdata is unchanged.
//  F requests are always memory reads; the fetch channel has no we/io inputs.
//  MemDataready while IDLE, IO or ACK: ignored.
//  Reset mid-access:
//   - Strobes go 0 and Databus goes Z at that edge. No ack is issued.
//   - The access is lost; requesters reissue after reset.
// CONFIGURATION
//  SAYEH_BUS_TIMEOUT_EN defined:
//   - A counter clears on MEM entry and increments each MEM cycle.
//   - If TIMEOUT cycles elapse without MemDataready, go to ACK with rdata = all ones
//     and bus_err=1 in the ack cycle.
//   - MemDataready=1 on the timeout cycle counts as normal completion, with no error.
//  SAYEH_BUS_TIMEOUT_EN undefined:
//   - MEM waits indefinitely. bus_err is tied 0 and TIMEOUT is unused.
// TESTING
//  1. F read 0x0040, memory ready immediately, data 0x1234
//     -> ReadMem high 1 cycle; f_ack at cycle 2; f_rdata=0x1234.
//  2. D write 0xBEEF to 0x0100, MemDataready low 3 cycles
//     -> WriteMem high 4 cycles; Databus=0xBEEF for all 4; d_ack once; then Databus Z.
//  3. f_req and d_req high together and both held for two accesses
//     -> order of grants is D, F, D; no channel is acked twice in a row while the other waits.
//  4. D IO read from 0x0007 with IO_WAIT=3, IO data 0x00A5
//     -> ReadIO high exactly 3 cycles; MemDataready toggling is ignored; d_rdata=0x00A5.
//  5. ExternalReset asserted during the 2nd MEM wait cycle
//     -> strobes 0 at the next edge; no ack; Addressbus=0; bus Z; a fresh request completes normally.
//  6. SAYEH_BUS_TIMEOUT_EN, TIMEOUT=8, MemDataready held 0
//     -> d_ack and bus_err pulse together after 8 MEM cycles; d_rdata=0xFFFF.

Source files
------------

// File: rtl/sayeh_bus_unit.sv
// rtl/sayeh_bus_unit.sv - SAYEH bus interface unit: F/D arbitration, memory/IO strobes, wait handshake
//
// Ports:
//   clk, ExternalReset                  clock, synchronous active-high reset
//   f_req/f_addr -> f_ack/f_rdata       fetch channel (memory reads only)
//   d_req/d_we/d_io/d_addr/d_wdata
//     -> d_ack/d_rdata                  data channel (memory or IO, read or write)
//   ReadMem/WriteMem/ReadIO/WriteIO     registered external strobes, at most one high
//   Addressbus                          registered address, holds between accesses
//   Databus                             driven only during WriteMem/WriteIO, else Z
//   MemDataready                        memory ready, sampled only in MEM
//   bus_err                             pulses with ack on a timed-out memory access
//
// Optional feature: define SAYEH_BUS_TIMEOUT_EN to bound memory waits to TIMEOUT cycles.
module sayeh_bus_unit #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int IO_WAIT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          ExternalReset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_io,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic          ReadIO,
    output logic          WriteIO,
    output logic [AW-1:0] Addressbus,
    inout  wire  [DW-1:0] Databus,
    input  logic          MemDataready,
    output logic          bus_err
);

    // One counter serves both the IO strobe length and the memory timeout.
    localparam int CNT_MAX = (TIMEOUT > IO_WAIT) ? TIMEOUT : IO_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] IO_LAST = CNT_W'(IO_WAIT - 1);
`ifdef SAYEH_BUS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {IDLE, MEM, IO, ACK} state_t;

    state_t           state;
    logic             gnt_d;    // granted channel of the current access is D
    logic             last_d;   // most recent grant went to D
    logic             lat_we;
    logic [DW-1:0]    wdata_q;
    logic [CNT_W-1:0] cnt;
    logic             pick_d;

    // D wins unless F is also waiting and D had the previous grant.
    always_comb begin
        pick_d = d_req && (!f_req || !last_d);
    end

    assign Databus = (WriteMem || WriteIO) ? wdata_q : {DW{1'bz}};

`ifdef SAYEH_BUS_TIMEOUT_EN
    logic bus_err_q;
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            state      <= IDLE;
            gnt_d      <= 1'b0;
            last_d     <= 1'b0;
            lat_we     <= 1'b0;
            wdata_q    <= '0;
            cnt        <= '0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
            f_rdata    <= '0;
            d_rdata    <= '0;
            ReadMem    <= 1'b0;
            WriteMem   <= 1'b0;
            ReadIO     <= 1'b0;
            WriteIO    <= 1'b0;
            Addressbus <= '0;
`ifdef SAYEH_BUS_TIMEOUT_EN
            bus_err_q  <= 1'b0;
`endif
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
`ifdef SAYEH_BUS_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (f_req || d_req) begin
                        gnt_d      <= pick_d;
                        last_d     <= pick_d;
                        lat_we     <= pick_d && d_we;
                        wdata_q    <= d_wdata;
                        Addressbus <= pick_d ? d_addr : f_addr;
                        cnt        <= '0;
                        if (pick_d && d_io) begin
                            state   <= IO;
                            ReadIO  <= !d_we;
                            WriteIO <= d_we;
                        end else begin
                            state    <= MEM;
                            ReadMem  <= !(pick_d && d_we);
                            WriteMem <= pick_d && d_we;
                        end
                    end
                end
                MEM: begin
                    cnt <= cnt + 1'b1;
                    if (MemDataready) begin
                        state    <= ACK;
                        ReadMem  <= 1'b0;
                        WriteMem <= 1'b0;
                        d_ack    <= gnt_d;
                        f_ack    <= !gnt_d;
                        if (!lat_we) begin
                            if (gnt_d) d_rdata <= Databus;
                            else       f_rdata <= Databus;
                        end
                    end
`ifdef SAYEH_BUS_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        state     <= ACK;
                        ReadMem   <= 1'b0;
                        WriteMem  <= 1'b0;
                        d_ack     <= gnt_d;
                        f_ack     <= !gnt_d;
                        bus_err_q <= 1'b1;
                        if (!lat_we) begin
                            if (gnt_d) d_rdata <= '1;
                            else       f_rdata <= '1;
                        end
                    end
`endif
                end
                IO: begin
                    if (cnt == IO_LAST) begin
                        state   <= ACK;
                        ReadIO  <= 1'b0;
                        WriteIO <= 1'b0;
                        d_ack   <= 1'b1;
                        if (!lat_we) d_rdata <= Databus;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    // req inputs are deliberately not looked at here.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
